// File: rtl/sum_control_unit_if.sv
// Handshake and datapath-control bundle between the sum controller and its
// surroundings (requester plus register-file/adder datapath).
interface sum_control_unit_if;
  logic       start;
  logic       iLe10;
  logic       rfsrcmuxsel;
  logic       rfwe;
  logic [1:0] waddr;
  logic [1:0] raddr1;
  logic [1:0] raddr2;
  logic       outLoad;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] iter_count;

  // Requester/datapath side: issues start and the status flag.
  modport master (
    output start, iLe10,
    input  rfsrcmuxsel, rfwe, waddr, raddr1, raddr2, outLoad,
    input  busy, done, error, iter_count
  );

  // Controller side.
  modport slave (
    input  start, iLe10,
    output rfsrcmuxsel, rfwe, waddr, raddr1, raddr2, outLoad,
    output busy, done, error, iter_count
  );
endinterface

// File: rtl/sum_control_unit.sv
// Moore controller that sequences the register-file/adder datapath to
// accumulate sum(1..10) into the output register, with a start/busy/done
// handshake and a watchdog on the number of ADD iterations.
// Register map: R0 = zero, R1 = i, R2 = sum, R3 = constant 1.
module sum_control_unit #(
  parameter int MAX_ITER = 16
) (
  input  logic          clk,
  input  logic          reset,
  sum_control_unit_if.slave bus
);

  localparam logic [7:0] MAX_ITER_L = MAX_ITER[7:0];

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_I,
    S_INIT_ONE,
    S_INIT_SUM,
    S_CHECK,
    S_ADD,
    S_INC,
    S_OUT,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] iter_cnt;

  // State register; reset returns to IDLE at once so every decoded output drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ADD counter: cleared on an accepted start, bumped when leaving ADD, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter_cnt <= 8'd0;
    end else if ((state == S_IDLE || state == S_ERR) && bus.start) begin
      iter_cnt <= 8'd0;
    end else if (state == S_ADD && iter_cnt != 8'hFF) begin
      iter_cnt <= iter_cnt + 8'd1;
    end else begin
      iter_cnt <= iter_cnt;
    end
  end

  // Next-state logic; start is only looked at from IDLE and ERR.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     state_next = bus.start ? S_INIT_I : S_IDLE;
      S_INIT_I:   state_next = S_INIT_ONE;
      S_INIT_ONE: state_next = S_INIT_SUM;
      S_INIT_SUM: state_next = S_CHECK;
      S_CHECK: begin
        if (!bus.iLe10) begin
          state_next = S_OUT;
        end else if (iter_cnt == MAX_ITER_L) begin
          state_next = S_ERR;
        end else begin
          state_next = S_ADD;
        end
      end
      S_ADD:      state_next = S_INC;
      S_INC:      state_next = S_CHECK;
      S_OUT:      state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      S_ERR:      state_next = bus.start ? S_INIT_I : S_ERR;
      default:    state_next = S_IDLE;
    endcase
  end

  // Moore output decode: everything is a pure function of the current state.
  always_comb begin
    bus.rfsrcmuxsel = 1'b0;
    bus.rfwe        = 1'b0;
    bus.waddr       = 2'd0;
    bus.raddr1      = 2'd0;
    bus.raddr2      = 2'd0;
    bus.outLoad     = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.error       = 1'b0;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
      end
      S_INIT_I: begin
        // R1 <- 1
        bus.busy        = 1'b1;
        bus.rfsrcmuxsel = 1'b1;
        bus.rfwe        = 1'b1;
        bus.waddr       = 2'd1;
      end
      S_INIT_ONE: begin
        // R3 <- 1
        bus.busy        = 1'b1;
        bus.rfsrcmuxsel = 1'b1;
        bus.rfwe        = 1'b1;
        bus.waddr       = 2'd3;
      end
      S_INIT_SUM: begin
        // R2 <- R0 + R0 = 0
        bus.busy   = 1'b1;
        bus.rfwe   = 1'b1;
        bus.waddr  = 2'd2;
      end
      S_CHECK: begin
        // present i so the datapath can evaluate i <= 10
        bus.busy   = 1'b1;
        bus.raddr1 = 2'd1;
      end
      S_ADD: begin
        // R2 <- R2 + R1
        bus.busy   = 1'b1;
        bus.rfwe   = 1'b1;
        bus.waddr  = 2'd2;
        bus.raddr1 = 2'd2;
        bus.raddr2 = 2'd1;
      end
      S_INC: begin
        // R1 <- R1 + R3
        bus.busy   = 1'b1;
        bus.rfwe   = 1'b1;
        bus.waddr  = 2'd1;
        bus.raddr1 = 2'd1;
        bus.raddr2 = 2'd3;
      end
      S_OUT: begin
        // outport <- R2 + R0
        bus.busy    = 1'b1;
        bus.raddr1  = 2'd2;
        bus.outLoad = 1'b1;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      S_ERR: begin
        bus.error = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.iter_count = iter_cnt;

endmodule

// File: tb/tb_sum_control_unit.sv
// Self-checking bench for sum_control_unit: drives it with a behavioural
// register-file/adder datapath and checks every cycle of each run against a
// schedule derived from the controller's state sequence.
module tb_sum_control_unit;
  localparam int MAX_ITER = 16;
  localparam int PERIOD   = 10;

  typedef enum int {
    P_IDLE, P_INIT_I, P_INIT_ONE, P_INIT_SUM, P_CHECK,
    P_ADD, P_INC, P_OUT, P_DONE, P_ERR
  } phase_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sum_control_unit_if bus();

  sum_control_unit #(.MAX_ITER(MAX_ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #(PERIOD/2) clk = ~clk;

  // Behavioural datapath: 4 x 8-bit register file (R0 reads as zero), adder, output register.
  logic [7:0] rf [4];
  logic [7:0] outport = 8'd0;
  int         mode    = 0;   // 0 = real datapath flag, 1 = flag forced 0, 2 = flag forced 1

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = 8'd0;
  end

  function automatic logic [7:0] rd(input logic [1:0] a);
    return (a == 2'd0) ? 8'd0 : rf[a];
  endfunction

  assign bus.iLe10 = (mode == 0) ? (rf[1] <= 8'd10) : (mode == 2);

  always @(posedge clk) begin
    if (bus.rfwe && bus.waddr != 2'd0)
      rf[bus.waddr] <= bus.rfsrcmuxsel ? 8'd1 : 8'(rd(bus.raddr1) + rd(bus.raddr2));
    if (bus.outLoad)
      outport <= 8'(rd(bus.raddr1) + rd(bus.raddr2));
  end

  int         vectors     = 0;
  int         miscompares = 0;
  int         prev_iter   = 0;
  bit         in_err      = 1'b0;
  logic [7:0] last_out    = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ctrl_vec();
    return {bus.rfsrcmuxsel, bus.rfwe, bus.waddr, bus.raddr1, bus.raddr2,
            bus.outLoad, bus.busy, bus.done, bus.error};
  endfunction

  // {rfsrcmuxsel, rfwe, waddr, raddr1, raddr2, outLoad, busy, done, error}
  function automatic logic [11:0] exp_ctrl(input phase_t p);
    case (p)
      P_INIT_I:   return 12'b1_1_01_00_00_0_1_0_0;
      P_INIT_ONE: return 12'b1_1_11_00_00_0_1_0_0;
      P_INIT_SUM: return 12'b0_1_10_00_00_0_1_0_0;
      P_CHECK:    return 12'b0_0_00_01_00_0_1_0_0;
      P_ADD:      return 12'b0_1_10_10_01_0_1_0_0;
      P_INC:      return 12'b0_1_01_01_11_0_1_0_0;
      P_OUT:      return 12'b0_0_00_10_00_1_1_0_0;
      P_DONE:     return 12'b0_0_00_00_00_0_1_1_0;
      P_ERR:      return 12'b0_0_00_00_00_0_0_0_1;
      default:    return 12'b0_0_00_00_00_0_0_0_0;
    endcase
  endfunction

  // Phase of the k-th cycle after start is accepted, for a run with n ADDs.
  function automatic phase_t phase_at(input int k, input int n, input bit err);
    if (k == 1) return P_INIT_I;
    if (k == 2) return P_INIT_ONE;
    if (k == 3) return P_INIT_SUM;
    if (k <= 3 + 3*n) begin
      case ((k - 4) % 3)
        0:       return P_CHECK;
        1:       return P_ADD;
        default: return P_INC;
      endcase
    end
    if (k == 3*n + 4) return P_CHECK;
    if (k == 3*n + 5) return err ? P_ERR : P_OUT;
    return P_DONE;
  endfunction

  // ADDs completed before cycle k.
  function automatic int iter_at(input int k, input int n);
    if (k <= 3) return 0;
    if (k <= 3 + 3*n) return ((k - 4) % 3 == 2) ? (k - 4) / 3 + 1 : (k - 4) / 3;
    return n;
  endfunction

  // One run from IDLE/ERR; k_reset > 0 asserts reset during that cycle and aborts.
  task automatic run(input int m, input bit noisy, input int k_reset);
    int         n;
    int         last;
    bit         err;
    logic [7:0] s;
    logic [7:0] i;
    logic [7:0] exp_out;
    logic [7:0] rf_save [4];

    mode = m;
    // Reference: the datapath keeps adding while i <= 10.
    n = 0; s = 8'd0; i = 8'd1;
    if (m == 0) begin
      while (i <= 8'd10) begin
        s = s + i; i = i + 8'd1; n++;
      end
    end else if (m == 2) begin
      n = MAX_ITER;
    end
    err     = (m == 2);
    last    = err ? 3*n + 5 : 3*n + 6;
    exp_out = (m == 0) ? s : (m == 1) ? 8'd0 : last_out;

    check("pre_ctrl", 32'(ctrl_vec()), 32'(exp_ctrl(in_err ? P_ERR : P_IDLE)));
    check("pre_iter", 32'(bus.iter_count), 32'(prev_iter));
    bus.start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= last; k++) begin
      check($sformatf("ctrl_m%0d_k%0d", m, k), 32'(ctrl_vec()), 32'(exp_ctrl(phase_at(k, n, err))));
      check($sformatf("iter_m%0d_k%0d", m, k), 32'(bus.iter_count), 32'(iter_at(k, n)));
      if (k == last && !err)
        check($sformatf("outport_m%0d", m), 32'(outport), 32'(exp_out));
      if (k == k_reset) begin
        bus.start = 1'b0;
        for (int r = 0; r < 4; r++) rf_save[r] = rf[r];
        reset = 1'b1;
        #1;
        check("rst_async_ctrl", 32'(ctrl_vec()), 32'd0);
        check("rst_async_iter", 32'(bus.iter_count), 32'd0);
        @(posedge clk);
        #1;
        for (int r = 1; r < 4; r++)
          check($sformatf("rst_rf%0d", r), 32'(rf[r]), 32'(rf_save[r]));
        check("rst_held_ctrl", 32'(ctrl_vec()), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        prev_iter = 0;
        in_err    = 1'b0;
        @(negedge clk);
        return;
      end
      bus.start = (noisy && k < last - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    if (err) begin
      for (int e = 0; e < 2; e++) begin
        check("err_hold_ctrl", 32'(ctrl_vec()), 32'(exp_ctrl(P_ERR)));
        check("err_outport", 32'(outport), 32'(exp_out));
        @(negedge clk);
      end
    end else begin
      check("post_idle", 32'(ctrl_vec()), 32'(exp_ctrl(P_IDLE)));
    end
    last_out  = exp_out;
    prev_iter = n;
    in_err    = err;
  endtask

  // start tied high: three runs, DONE pulses 37 cycles apart.
  task automatic back_to_back();
    int t    = 0;
    int prev = -1;
    int seen = 0;
    mode = 0;
    check("b2b_pre", 32'(ctrl_vec()), 32'(exp_ctrl(P_IDLE)));
    bus.start = 1'b1;
    while (seen < 3 && t < 200) begin
      @(negedge clk);
      t++;
      if (bus.done) begin
        check("b2b_out", 32'(outport), 32'd55);
        if (prev >= 0) check("b2b_gap", 32'(t - prev), 32'd37);
        else           check("b2b_first", 32'(t), 32'd36);
        prev = t;
        seen++;
      end
    end
    bus.start = 1'b0;
    check("b2b_runs", 32'(seen), 32'd3);
    @(negedge clk);
    last_out  = 8'd55;
    prev_iter = 10;
    in_err    = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 32'(ctrl_vec()), 32'd0);
    check("reset_iter", 32'(bus.iter_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(0, 1'b0, 0);          // nominal
    run(0, 1'b1, 0);          // extra start pulses while busy
    back_to_back();
    run(2, 1'b1, 0);          // watchdog
    run(0, 1'b0, 0);          // recovery from ERR
    run(1, 1'b0, 0);          // zero-iteration
    run(0, 1'b1, 17);         // reset during the 5th ADD
    run(0, 1'b0, 0);

    for (int r = 0; r < 5; r++) begin
      int gap;
      gap = (in_err) ? 0 : int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        check("gap_idle", 32'(ctrl_vec()), 32'(exp_ctrl(P_IDLE)));
        @(negedge clk);
      end
      run(int'($urandom_range(0, 2)), 1'b1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(PERIOD * 20000);
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
